// File: rtl/clockworks_pkg.sv
// Shared types and helpers for the clockworks reset/clock-enable sequencer.
package clockworks_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clockworks_ce_divider.sv
// One domain's clock-enable divider: first pulse DIV cycles after en rises, then every DIV.
module ce_divider
  import clockworks_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic ce
);

  if (DIV == 1) begin : g_pass
    logic unused_div;
    assign unused_div = clk ^ reset;
    assign ce = en;
  end else begin : g_cnt
    localparam int CW = cnt_w(DIV);
    logic [CW-1:0] cnt;
    logic          hit;

    always_ff @(posedge clk) begin
      if (!reset || !en) begin
        cnt <= '0;
        hit <= 1'b0;
      end else begin
        hit <= (cnt == CW'(DIV - 1));
        cnt <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
      end
    end

    // Gate with en so a domain re-entering reset drops ce in the same cycle.
    assign ce = hit & en;
  end

endmodule

// File: rtl/clockworks_seq.sv
// Staged reset release with per-domain clock enables, debounced button and optional
// watchdog (enabled by defining CLOCKWORKS_WDT_EN).
//
// state | meaning
// HOLD  | all domains in reset, counting HOLD_CYCLES
// STAGE | releasing domains one every STAGE_GAP cycles
// RUN   | all domains released, locked=1
module clockworks_seq
  import clockworks_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int DIV_BASE    = 2,
  parameter int DEBOUNCE    = 8,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_n,
  input  logic               wdt_kick,
  output logic [N_DOM-1:0]   rst_n_out,
  output logic [N_DOM-1:0]   ce,
  output logic               locked,
  output logic [STATE_W-1:0] state,
  output logic               wdt_bite
);

  localparam int TMAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int TW   = cnt_w(TMAX);
  localparam int IW   = cnt_w(N_DOM + 1);
  localparam int DW   = cnt_w(DEBOUNCE);

  state_t        st;
  logic [TW-1:0] tmr;
  logic [IW-1:0] idx;
  logic          s1, s2, fired, req, bite;
  logic [DW-1:0] dcnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      dcnt  <= '0;
      fired <= 1'b0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      if (s2) begin
        dcnt  <= '0;
        fired <= 1'b0;
      end else begin
        if (req) fired <= 1'b1;
        if (dcnt != DW'(DEBOUNCE - 1)) dcnt <= dcnt + 1'b1;
      end
    end
  end

  // dcnt holds the number of earlier consecutive low cycles, so this is the DEBOUNCE-th.
  assign req = !s2 && !fired && (dcnt == DW'(DEBOUNCE - 1));

`ifdef CLOCKWORKS_WDT_EN
  localparam int WW = cnt_w(WDT_CYCLES);
  logic [WW-1:0] wcnt;

  always_ff @(posedge clk) begin
    if (!reset || st != RUN) wcnt <= '0;
    else if (wdt_kick)       wcnt <= '0;
    else                     wcnt <= wcnt + 1'b1;
  end

  assign bite = (st == RUN) && !wdt_kick && (wcnt == WW'(WDT_CYCLES - 1));
`else
  logic unused_kick;
  assign unused_kick = wdt_kick;
  assign bite        = 1'b0;
`endif

  assign wdt_bite = bite;

  always_ff @(posedge clk) begin
    if (!reset || req || bite) begin
      st        <= HOLD;
      tmr       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      locked    <= 1'b0;
    end else begin
      case (st)
        HOLD: begin
          if (tmr == TW'(HOLD_CYCLES - 1)) begin
            st        <= STAGE;
            tmr       <= '0;
            idx       <= IW'(1);
            rst_n_out <= N_DOM'(1);
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        STAGE: begin
          if (idx == IW'(N_DOM)) begin
            st     <= RUN;
            locked <= 1'b1;
          end else if (tmr == TW'(STAGE_GAP - 1)) begin
            tmr       <= '0;
            idx       <= idx + 1'b1;
            rst_n_out <= rst_n_out | (N_DOM'(1) << idx);
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RUN:     st <= RUN;
        default: st <= HOLD;
      endcase
    end
  end

  assign state = st;

  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    ce_divider #(.DIV(DIV_BASE << i)) u_div (
      .clk   (clk),
      .reset (reset),
      .en    (rst_n_out[i]),
      .ce    (ce[i])
    );
  end

endmodule

// File: tb/tb_clockworks_seq.sv
// Self-checking bench for clockworks_seq: table checkpoints, hand sequences and a
// randomized run against a cycles-since-HOLD-entry reference model.
module tb_clockworks_seq;
  localparam int N   = 3;
  localparam int H   = 16;
  localparam int G   = 4;
  localparam int DB  = 2;
  localparam int DEB = 8;
`ifdef CLOCKWORKS_WDT_EN
  localparam int W   = 32;
`else
  localparam int W   = 1024;
`endif
  localparam int LOCK_T = H + (N - 1) * G + 1;

  logic clk = 1'b0, reset = 1'b0, btn_n = 1'b1, wdt_kick = 1'b0;
  logic [N-1:0] rst_n_out, ce;
  logic locked, wdt_bite;
  logic [1:0] state;

  clockworks_seq #(.N_DOM(N), .HOLD_CYCLES(H), .STAGE_GAP(G), .DIV_BASE(DB),
                   .DEBOUNCE(DEB), .WDT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .wdt_kick(wdt_kick),
    .rst_n_out(rst_n_out), .ce(ce), .locked(locked), .state(state), .wdt_bite(wdt_bite));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Reference model: t = cycles since HOLD entry; sync pipeline and low-run length.
  bit m_rst = 1'b1;
  int t = 0;
  bit b1 = 1'b1, b2 = 1'b1, fired = 1'b0;
  int lowrun = 0, wc = 0;

  logic [N-1:0] s_rst, s_ce;
  logic [1:0]   s_st;
  logic         s_lk, s_bite;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic step();
    logic [N-1:0] er, ec;
    logic [1:0] es;
    logic el, eb;
    bit req;
    int r, d;
    @(negedge clk);
    s_rst = rst_n_out; s_ce = ce; s_st = state; s_lk = locked; s_bite = wdt_bite;
    er = '0; ec = '0; es = 2'd0; el = 1'b0; eb = 1'b0;
    if (!m_rst) begin
      for (int i = 0; i < N; i++) begin
        r = H + i * G;
        d = DB << i;
        if (t >= r) begin
          er[i] = 1'b1;
          if (d == 1 || (t > r && (t - r) % d == 0)) ec[i] = 1'b1;
        end
      end
      es = (t < H) ? 2'd0 : (t < LOCK_T) ? 2'd1 : 2'd2;
      el = (t >= LOCK_T);
`ifdef CLOCKWORKS_WDT_EN
      eb = el && (wc == W - 1) && !wdt_kick;
`endif
    end
    tests++;
    if (s_rst !== er || s_ce !== ec || s_st !== es || s_lk !== el || s_bite !== eb) begin
      fails++;
      $display("FAIL model t=%0d got rst=%b ce=%b st=%0d lk=%b bite=%b want rst=%b ce=%b st=%0d lk=%b bite=%b",
               t, s_rst, s_ce, s_st, s_lk, s_bite, er, ec, es, el, eb);
    end
    req = !b2 && (lowrun == DEB) && !fired;
    @(posedge clk);
    if (!reset) begin
      m_rst = 1'b1; t = 0; b1 = 1'b1; b2 = 1'b1; lowrun = 0; fired = 1'b0; wc = 0;
    end else begin
      fired = b2 ? 1'b0 : (fired | req);
      if (!m_rst && t >= LOCK_T && !(req || eb)) wc = wdt_kick ? 0 : wc + 1;
      else wc = 0;
      t = (req || eb) ? 0 : t + 1;
      b2 = b1;
      b1 = btn_n;
      lowrun = b2 ? 0 : lowrun + 1;
      m_rst = 1'b0;
    end
    #1;
  endtask

  typedef struct {
    int       cyc;
    bit       btn;
    bit [2:0] rst;
    bit [2:0] cev;
    bit [1:0] st;
    bit       lk;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int k0, n, lvl, run;
    bit seen, drop;
    tbl[0]  = '{0,  1, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[1]  = '{15, 1, 3'b000, 3'b000, 2'd0, 1'b0};
    tbl[2]  = '{16, 1, 3'b001, 3'b000, 2'd1, 1'b0};
    tbl[3]  = '{18, 1, 3'b001, 3'b001, 2'd1, 1'b0};
    tbl[4]  = '{19, 1, 3'b001, 3'b000, 2'd1, 1'b0};
    tbl[5]  = '{20, 1, 3'b011, 3'b001, 2'd1, 1'b0};
    tbl[6]  = '{24, 1, 3'b111, 3'b011, 2'd1, 1'b0};
    tbl[7]  = '{25, 1, 3'b111, 3'b000, 2'd2, 1'b1};
    tbl[8]  = '{28, 1, 3'b111, 3'b011, 2'd2, 1'b1};
    tbl[9]  = '{32, 1, 3'b111, 3'b111, 2'd2, 1'b1};
    tbl[10] = '{34, 1, 3'b111, 3'b001, 2'd2, 1'b1};

    @(posedge clk); #1;
    repeat (3) step();
    chk("reset_rst", 32'(s_rst), 0);
    chk("reset_ce", 32'(s_ce), 0);
    chk("reset_state", 32'(s_st), 0);
    chk("reset_lk_bite", {s_lk, s_bite}, 0);

    // Release sequence checkpoints; cycle 0 is the first cycle with reset high.
    reset = 1'b1;
    wdt_kick = 1'b1;
    for (int c = 0; c <= 34; c++) begin
      btn_n = 1'b1;
      for (int k = 0; k < 11; k++) if (tbl[k].cyc == c) btn_n = tbl[k].btn;
      step();
      for (int k = 0; k < 11; k++) begin
        if (tbl[k].cyc == c) begin
          chk($sformatf("tbl_rst_c%0d", c), 32'(s_rst), 32'(tbl[k].rst));
          chk($sformatf("tbl_ce_c%0d", c), 32'(s_ce), 32'(tbl[k].cev));
          chk($sformatf("tbl_st_c%0d", c), {s_st, s_lk}, {tbl[k].st, tbl[k].lk});
        end
      end
    end

    // Seven-cycle press is ignored.
    btn_n = 1'b0;
    repeat (7) step();
    btn_n = 1'b1;
    repeat (12) step();
    chk("btn7_locked", 32'(s_lk), 1);
    chk("btn7_rst", 32'(s_rst), 3'b111);

    // Eight-cycle press restarts the whole sequence.
    btn_n = 1'b0;
    repeat (8) step();
    btn_n = 1'b1;
    step();
    step();
    chk("btn8_before", 32'(s_rst), 3'b111);
    step();
    chk("btn8_rst_low", 32'(s_rst), 0);
    chk("btn8_state", 32'(s_st), 0);
    repeat (15) step();
    chk("btn8_t15", 32'(s_rst), 0);
    step();
    chk("btn8_t16", 32'(s_rst), 3'b001);
    repeat (8) step();
    chk("btn8_t24", 32'(s_rst), 3'b111);
    step();
    chk("btn8_t25_lock", {s_st, s_lk}, {2'd2, 1'b1});

    // Reset asserted in STAGE with only domain 0 released.
    reset = 1'b0; step();
    reset = 1'b1;
    repeat (18) step();
    chk("stage_pre", 32'(s_rst), 3'b001);
    reset = 1'b0;
    step();
    chk("stage_rst_before_edge", 32'(s_rst), 3'b001);
    reset = 1'b1;
    step();
    chk("stage_rst_rst", 32'(s_rst), 0);
    chk("stage_rst_other", {s_ce, s_st, s_lk, s_bite}, 0);

    // Randomized button runs, kicks and occasional resets against the model.
    lvl = 1; run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lvl = 1 - lvl;
        run = lvl ? $urandom_range(1, 60) : $urandom_range(1, 12);
      end
      btn_n = lvl[0];
      run--;
      wdt_kick = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 499) != 0);
      step();
    end

    reset = 1'b1; btn_n = 1'b1;
`ifdef CLOCKWORKS_WDT_EN
    wdt_kick = 1'b0;
    reset = 1'b0; step();
    reset = 1'b1;
    repeat (26) step();
    chk("wdt_run_entry", 32'(s_lk), 1);
    n = 0;
    while (!s_bite && n < 100) begin step(); n++; end
    chk("wdt_bite_delay", n, 31);
    step();
    chk("wdt_hold_after", 32'(s_st), 0);
    reset = 1'b0; step();
    reset = 1'b1;
    repeat (26) step();
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      wdt_kick = (k % 20 == 0);
      step();
      if (s_bite) seen = 1'b1;
    end
    chk("wdt_kicked_no_bite", 32'(seen), 0);
`else
    wdt_kick = 1'b0;
    repeat (30) step();
    chk("nowdt_locked_start", 32'(s_lk), 1);
    seen = 1'b0; drop = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      step();
      if (s_bite) seen = 1'b1;
      if (!s_lk) drop = 1'b1;
    end
    chk("nowdt_bite", 32'(seen), 0);
    chk("nowdt_lock_drop", 32'(drop), 0);
`endif
    k0 = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails + k0);
    $finish;
  end

endmodule

// File: doc/clockworks_seq.md
CLOCKWORKS_SEQ -- requirements
Module: clockworks_seq

Interface
REQ-001 SHALL have parameter N_DOM, default 3: number of downstream reset/clock-enable domains (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16: reset hold length after any reset cause (>=1).
REQ-003 SHALL have parameter STAGE_GAP, default 4: cycles between successive domain releases (>=1).
REQ-004 SHALL have parameter DIV_BASE, default 2: base clock-enable divisor (>=1); domain i divides by DIV_BASE<<i.
REQ-005 SHALL have parameter DEBOUNCE, default 8: consecutive synchronized-low cycles that make a button request (>=1).
REQ-006 SHALL have parameter WDT_CYCLES, default 1024: watchdog timeout in cycles (>=2).
REQ-007 clk  input  1  single design clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-low reset.
REQ-009 btn_n  input  1  asynchronous board reset button, active-low.
REQ-010 wdt_kick  input  1  watchdog restart strobe, one cycle.
REQ-011 rst_n_out  output  N_DOM  per-domain active-low reset.
REQ-012 ce  output  N_DOM  per-domain one-cycle clock-enable pulse.
REQ-013 locked  output  1  high when all domains are released.
REQ-014 state  output  2  current state encoding: HOLD=0, STAGE=1, RUN=2.
REQ-015 wdt_bite  output  1  one-cycle pulse on watchdog timeout.

Function
REQ-016 btn_n SHALL pass through a 2-flop synchronizer before use; a request SHALL fire when the synchronized value has been low for DEBOUNCE consecutive cycles, and SHALL re-fire only after it has returned high.
REQ-017 The FSM SHALL have states HOLD, STAGE and RUN; HOLD counts HOLD_CYCLES cycles, then moves to STAGE.
REQ-018 rst_n_out[i] SHALL rise exactly HOLD_CYCLES + i*STAGE_GAP cycles after entry to HOLD, and once high SHALL stay high until the next HOLD entry.
REQ-019 The FSM SHALL move from STAGE to RUN one cycle after rst_n_out[N_DOM-1] rises; locked SHALL be 1 exactly while in RUN.
REQ-020 A button request in any state, including HOLD, SHALL re-enter HOLD with counters cleared and all rst_n_out low in the next cycle.
REQ-021 ce[i] SHALL be 0 while rst_n_out[i] is low, and SHALL then pulse for one cycle every DIV_BASE<<i cycles, with the first pulse DIV_BASE<<i cycles after release; a divisor of 1 SHALL give ce[i] constantly 1 while released.
REQ-022 Divider counters SHALL be sized by $clog2 of the largest divisor and SHALL wrap with no drift.
REQ-023 Simultaneous button request and watchdog timeout SHALL produce one HOLD entry, with wdt_bite still pulsed.

Reset
REQ-024 While reset is low, the block SHALL hold: state=HOLD, all counters=0, rst_n_out=0, ce=0, locked=0, wdt_bite=0, and synchronizer flops=1.
REQ-025 Reset release SHALL count as the HOLD entry used for REQ-018 timing, with the first cycle at reset=1 as cycle 0.

Configuration
REQ-026 With macro CLOCKWORKS_WDT_EN defined, the watchdog SHALL count only in RUN and be cleared by wdt_kick; reaching WDT_CYCLES-1 without a kick SHALL pulse wdt_bite and force HOLD; a kick in the timeout cycle SHALL win.
REQ-027 Without CLOCKWORKS_WDT_EN, the watchdog SHALL be absent, wdt_kick SHALL be ignored, and wdt_bite SHALL be tied to 0; the port list SHALL be unchanged.

Structure
REQ-028 A shared package clockworks_pkg SHALL hold the state enum (HOLD/STAGE/RUN) and the 2-bit state width constant.
REQ-029 Each domain's divider SHALL be one instance of sub-module ce_divider (parameter DIV; ports clk, reset, en, ce).

Verification
REQ-030 Defaults, reset released at cycle 0 -> rst_n_out bits rise at cycles 16, 20 and 24; locked rises at 25; state reads 0, then 1, then 2.
REQ-031 Defaults, after lock -> ce[0] every 2 cycles, ce[1] every 4, ce[2] every 8; each first pulse is its divisor in cycles after that domain's release.
REQ-032 btn_n low for 7 cycles, then high -> no effect; low for 8 cycles -> all rst_n_out low the next cycle and the full sequence from REQ-030 restarts.
REQ-033 CLOCKWORKS_WDT_EN, WDT_CYCLES=32, no kicks -> wdt_bite pulses 31 cycles after RUN entry and HOLD follows; kicking every 20 cycles -> no bite over 1000 cycles.
REQ-034 reset pulled low during STAGE with rst_n_out=3'b001 -> all outputs take REQ-024 values the next cycle.
REQ-035 Without CLOCKWORKS_WDT_EN, no kicks for 5000 cycles -> wdt_bite stays 0 and locked stays 1.
